if_neuron_scheduler: RTL

Time-multiplexed controller that shares one integrate-and-fire update datapath among `N_NEURONS` virtual neurons. It holds every membrane potential in a local register array and accepts current-injection events over a valid/ready port. It applies saturating integrate, threshold and subtract-reset updates, and queues the resulting spike events in an output FIFO. It sits between the input encoder and the spike router in the SNN core.

---
 rtl/if_neuron_pkg.sv | 13 +
 rtl/spike_fifo.sv | 68 ++++++
 rtl/if_neuron_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/if_neuron_pkg.sv
// Shared constants and types for the integrate-and-fire neuron scheduler.
package if_neuron_pkg;

   localparam int unsigned DefWidth  = 8;
   localparam int unsigned DefThresh = 230;
   // Widest neuron index supported (64 neurons).
   localparam int unsigned MaxIdxW   = 6;

   typedef struct packed {
      logic [MaxIdxW-1:0] idx;
   } spike_evt_t;

endpackage

// File: rtl/spike_fifo.sv
// Synchronous FIFO for spike events. The head is read straight from storage registers.
// Pushes while full and pops while empty are ignored.
module spike_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_i,
   input  logic [Width-1:0]        data_i,
   input  logic                    pop_i,
   output logic [Width-1:0]        head_o,
   output logic [$clog2(Depth):0]  count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [PtrW:0] FullCnt = Depth[PtrW:0];

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [PtrW:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Next-state for storage, pointers and occupancy. Pointers wrap because Depth is a power of two.
   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      do_pop  = pop_i && (count_q != '0);
      do_push = push_i && (count_q != FullCnt);
      if (do_push) begin
         mem_d[wptr_q] = data_i;
         wptr_d        = wptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PtrW+1)'(1);
         2'b01:   count_d = count_q - (PtrW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/if_neuron_scheduler.sv
// Time-multiplexed integrate-and-fire scheduler: one update datapath shared by N_NEURONS
// membrane registers, a single stage register, and an output spike FIFO.
// Optional feature macro: IF_NEURON_REFRAC_EN adds per-neuron refractory counters.
module if_neuron_scheduler
   import if_neuron_pkg::*;
#(
   parameter int unsigned N_NEURONS     = 8,
   parameter int unsigned WIDTH         = DefWidth,
   parameter int unsigned THRESH        = DefThresh,
   parameter int unsigned EVT_DEPTH     = 4,
   parameter int unsigned REFRAC_EVENTS = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [$clog2(N_NEURONS)-1:0] in_idx,
   input  logic [WIDTH-1:0]             in_current,
   output logic                         spk_valid,
   input  logic                         spk_ready,
   output logic [$clog2(N_NEURONS)-1:0] spk_idx,
   output logic [15:0]                  spk_count,
   output logic                         busy
);

   localparam int unsigned IdxW = $clog2(N_NEURONS);
   localparam int unsigned CntW = $clog2(EVT_DEPTH) + 1;
   localparam int unsigned RefW = (REFRAC_EVENTS > 0) ? $clog2(REFRAC_EVENTS + 1) : 1;
   localparam logic [WIDTH-1:0] ThreshV = THRESH[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SatMax  = '1;
   localparam logic [CntW:0]    DepthV  = EVT_DEPTH[CntW:0];

   logic [WIDTH-1:0] state_q [N_NEURONS];
   logic [WIDTH-1:0] state_d [N_NEURONS];
   logic             stg_valid_q, stg_valid_d;
   logic [IdxW-1:0]  stg_idx_q, stg_idx_d;
   logic [WIDTH-1:0] stg_cur_q, stg_cur_d;
   logic [15:0]      spk_count_q, spk_count_d;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sat;
   logic             fire, refrac, push, pop, accept;
   logic [CntW-1:0]  fifo_count;
   logic [CntW:0]    occupancy;
   spike_evt_t       push_evt, head_evt;
   logic             unused_head;

`ifdef IF_NEURON_REFRAC_EN
   localparam logic [RefW-1:0] RefInit = REFRAC_EVENTS[RefW-1:0];
   logic [RefW-1:0] ref_q [N_NEURONS];
   logic [RefW-1:0] ref_d [N_NEURONS];
   assign refrac = (ref_q[stg_idx_q] != '0);
`else
   logic [RefW-1:0] unused_refrac;
   assign unused_refrac = RefW'(REFRAC_EVENTS);
   assign refrac        = 1'b0;
`endif

   // Counting the staged event in occupancy guarantees a free FIFO slot for its spike.
   assign occupancy = {1'b0, fifo_count} + {{CntW{1'b0}}, stg_valid_q};
   assign in_ready  = rst_n && !clr && (occupancy < DepthV);
   assign accept    = in_valid && in_ready;

   // Saturating integrate and threshold on the staged event.
   always_comb begin
      sum  = {1'b0, state_q[stg_idx_q]} + {1'b0, stg_cur_q};
      sat  = sum[WIDTH] ? SatMax : sum[WIDTH-1:0];
      fire = (sat >= ThreshV);
   end

   // Membrane, refractory and spike-count next state; clr drops the staged event unapplied.
   always_comb begin
      state_d     = state_q;
      spk_count_d = spk_count_q;
      push        = 1'b0;
`ifdef IF_NEURON_REFRAC_EN
      ref_d       = ref_q;
`endif
      if (clr) begin
         for (int unsigned i = 0; i < N_NEURONS; i++) begin
            state_d[i] = '0;
`ifdef IF_NEURON_REFRAC_EN
            ref_d[i]   = '0;
`endif
         end
      end else if (stg_valid_q) begin
         if (refrac) begin
`ifdef IF_NEURON_REFRAC_EN
            ref_d[stg_idx_q] = ref_q[stg_idx_q] - RefW'(1);
`endif
         end else if (fire) begin
            state_d[stg_idx_q] = sat - ThreshV;
            push               = 1'b1;
`ifdef IF_NEURON_REFRAC_EN
            ref_d[stg_idx_q]   = RefInit;
`endif
         end else begin
            state_d[stg_idx_q] = sat;
         end
      end
      if (push && (spk_count_q != 16'hFFFF)) begin
         spk_count_d = spk_count_q + 16'd1;
      end
   end

   // Stage register load; an idle cycle empties the stage.
   always_comb begin
      stg_valid_d = accept;
      stg_idx_d   = stg_idx_q;
      stg_cur_d   = stg_cur_q;
      if (accept) begin
         stg_idx_d = in_idx;
         stg_cur_d = in_current;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_NEURONS; i++) begin
            state_q[i] <= '0;
`ifdef IF_NEURON_REFRAC_EN
            ref_q[i]   <= '0;
`endif
         end
         stg_valid_q <= 1'b0;
         stg_idx_q   <= '0;
         stg_cur_q   <= '0;
         spk_count_q <= '0;
      end else begin
         state_q     <= state_d;
`ifdef IF_NEURON_REFRAC_EN
         ref_q       <= ref_d;
`endif
         stg_valid_q <= stg_valid_d;
         stg_idx_q   <= stg_idx_d;
         stg_cur_q   <= stg_cur_d;
         spk_count_q <= spk_count_d;
      end
   end

   // Build the pushed event with the index zero-extended into the packed struct.
   always_comb begin
      push_evt                = '0;
      push_evt.idx[IdxW-1:0]  = stg_idx_q;
   end

   spike_fifo #(
      .Depth (EVT_DEPTH),
      .Width ($bits(spike_evt_t))
   ) u_spike_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (push_evt),
      .pop_i   (pop),
      .head_o  (head_evt),
      .count_o (fifo_count)
   );

   assign spk_valid   = (fifo_count != '0);
   assign pop         = spk_ready && spk_valid;
   assign spk_idx     = head_evt.idx[IdxW-1:0];
   assign unused_head = ^head_evt;
   assign spk_count   = spk_count_q;
   assign busy        = stg_valid_q || (fifo_count != '0);

endmodule
